// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller.
//   - opcode / funct field encodings of the 16-bit instruction
//   - alucontrol codes driven to the ALU
//   - alusrcb and pcsrc mux select encodings
//   - controller FSM state type and ALU operation class type
package mips_pkg;

  // instr[15:10]
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // instr[5:0] for R-type
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // ALU B source select
  localparam logic [1:0] SrcbReg   = 2'b00;
  localparam logic [1:0] SrcbOne   = 2'b01;
  localparam logic [1:0] SrcbImm   = 2'b10;
  localparam logic [1:0] SrcbBrOff = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  // Which ALU operation a state asks for; AluClsFunct defers to the funct field.
  typedef enum logic [1:0] {
    AluClsAdd,
    AluClsSub,
    AluClsFunct
  } alu_cls_e;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWr,
    StMemWb,
    StExec,
    StAluWb,
    StBranch,
    StAddiEx,
    StAddiWb,
    StJump
  } state_e;

  // All datapath controls in one bundle so reset gating is a single mux.
  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps an operation class and the funct field to an ALU code.
//   cls_i         : requested class (add, sub, or decode from funct)
//   funct_i       : instr[5:0]
//   alucontrol_o  : ALU operation code
//   funct_valid_o : low when class is funct and funct is not a known R-type op
module mc_aludec
  import mips_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_valid_o
);

  always_comb begin
    alucontrol_o  = AluAnd;
    funct_valid_o = 1'b1;
    unique case (cls_i)
      AluClsAdd: alucontrol_o = AluAdd;
      AluClsSub: alucontrol_o = AluSub;
      AluClsFunct: begin
        case (funct_i)
          FnAdd:   alucontrol_o = AluAdd;
          FnSub:   alucontrol_o = AluSub;
          FnAnd:   alucontrol_o = AluAnd;
          FnOr:    alucontrol_o = AluOr;
          FnSlt:   alucontrol_o = AluSlt;
          default: begin
            alucontrol_o  = AluAnd;
            funct_valid_o = 1'b0;
          end
        endcase
      end
      default: alucontrol_o = AluAnd;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit for the 16-bit-instruction / 8-bit-data MIPS core.
// Sequences fetch, decode, execute, memory and writeback over a shared memory,
// stalling in memory states until memready.
//   clk, reset (async active-low)
//   op, funct       : instruction fields from the IR
//   zero            : ALU zero flag (gates pcen in BRANCH)
//   memready        : memory completes the current access this cycle
//   pcen .. alucontrol : datapath enables, mux selects and ALU operation
//   illegal         : one-cycle pulse on unknown opcode (DECODE) or funct (EXEC)
module mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_e   state_q, state_d;
  ctrl_t    ctrl, ctrl_out;
  alu_cls_e alu_cls;
  logic     alu_used;
  logic     funct_valid;
  logic [2:0] aludec_ctrl;

  mc_aludec u_aludec (
    .cls_i         (alu_cls),
    .funct_i       (funct),
    .alucontrol_o  (aludec_ctrl),
    .funct_valid_o (funct_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl     = '0;
    alu_cls  = AluClsAdd;
    alu_used = 1'b0;

    unique case (state_q)
      StFetch: begin
        // Mux selects stay put during a stall; only the strobes wait on memready.
        ctrl.irwrite = memready;
        ctrl.pcen    = memready;
        ctrl.alusrcb = SrcbOne;
        ctrl.pcsrc   = PcAlu;
        alu_used     = 1'b1;
        if (memready) state_d = StDecode;
      end
      StDecode: begin
        // Branch target is computed speculatively into ALUOut.
        ctrl.alusrcb = SrcbBrOff;
        alu_used     = 1'b1;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcbImm;
        alu_used     = 1'b1;
        state_d      = (op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        ctrl.iord = 1'b1;
        if (memready) state_d = StMemWb;
      end
      StMemWr: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = memready;
        if (memready) state_d = StFetch;
      end
      StMemWb: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        state_d       = StFetch;
      end
      StExec: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcbReg;
        alu_cls      = AluClsFunct;
        alu_used     = 1'b1;
        if (funct_valid) begin
          state_d = StAluWb;
        end else begin
          ctrl.illegal = 1'b1;
          state_d      = StFetch;
        end
      end
      StAluWb: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        state_d       = StFetch;
      end
      StBranch: begin
        ctrl.alusrca = 1'b1;
        ctrl.pcsrc   = PcAluOut;
        ctrl.pcen    = zero;
        alu_cls      = AluClsSub;
        alu_used     = 1'b1;
        state_d      = StFetch;
      end
      StAddiEx: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SrcbImm;
        alu_used     = 1'b1;
        state_d      = StAddiWb;
      end
      StAddiWb: begin
        ctrl.regwrite = 1'b1;
        state_d       = StFetch;
      end
      StJump: begin
        ctrl.pcsrc = PcJump;
        ctrl.pcen  = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase

    ctrl.alucontrol = alu_used ? aludec_ctrl : 3'b000;
  end

  // Outputs are forced low for the whole reset window, even though the state
  // register already reads FETCH and FETCH strobes would follow memready.
  assign ctrl_out = reset ? ctrl : '0;

  assign pcen       = ctrl_out.pcen;
  assign iord       = ctrl_out.iord;
  assign memwrite   = ctrl_out.memwrite;
  assign irwrite    = ctrl_out.irwrite;
  assign regdst     = ctrl_out.regdst;
  assign memtoreg   = ctrl_out.memtoreg;
  assign regwrite   = ctrl_out.regwrite;
  assign alusrca    = ctrl_out.alusrca;
  assign alusrcb    = ctrl_out.alusrcb;
  assign pcsrc      = ctrl_out.pcsrc;
  assign alucontrol = ctrl_out.alucontrol;
  assign illegal    = ctrl_out.illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each test pushes per-cycle stimulus and
// the expected output vector, then drains the queues cycle by cycle.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  int total = 0;
  int bad   = 0;
  int mw_count = 0;

  typedef struct packed {
    logic rst;
    logic mr;
    logic z;
  } step_t;

  step_t       stim_q[$];
  logic [15:0] exp_q[$];

  logic [15:0] outs;
  assign outs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, alucontrol, illegal};

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memready   (memready),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write strobes actually seen by memory at clock edges.
  always @(posedge clk) if (memwrite === 1'b1) mw_count <= mw_count + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  // Expected-vector builders, one per state.
  function automatic logic [15:0] mk(input logic pc, io, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, ps, input logic [2:0] ac,
                                     input logic il);
    return {pc, io, mw, irw, rd, m2r, rw, sa, sb, ps, ac, il};
  endfunction

  function automatic logic [15:0] e_fetch(input logic mr);
    return mk(mr, 0, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
  endfunction
  function automatic logic [15:0] e_decode(input logic il);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, il);
  endfunction
  function automatic logic [15:0] e_memadr();
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
  endfunction
  function automatic logic [15:0] e_memrd();
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [15:0] e_memwr(input logic mr);
    return mk(0, 1, mr, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [15:0] e_memwb();
    return mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [15:0] e_exec(input logic [2:0] ac, input logic il);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, ac, il);
  endfunction
  function automatic logic [15:0] e_aluwb();
    return mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [15:0] e_addiwb();
    return mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
  endfunction
  function automatic logic [15:0] e_branch(input logic z);
    return mk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
  endfunction
  function automatic logic [15:0] e_jump();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);
  endfunction

  task automatic add(input logic rst_v, input logic mr_v, input logic z_v,
                     input logic [15:0] e);
    stim_q.push_back('{rst: rst_v, mr: mr_v, z: z_v});
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    step_t s;
    logic [15:0] e;
    int n = 0;
    op = 6'b101011;
    add(0, 1, 0, 16'h0);
    add(0, 1, 1, 16'h0);
    add(0, 0, 0, 16'h0);
    add(1, 0, 0, e_fetch(0));
    add(1, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; memready = s.mr; zero = s.z;
      #1;
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL reset cyc%0d: got=%h want=%h", n, outs, e);
      end
      n++;
    end
  endtask

  task automatic test_lw();
    step_t s;
    logic [15:0] e;
    int n = 0;
    op = 6'b100011; funct = 6'b000000;
    add(1, 1, 0, e_fetch(1));
    add(1, 1, 0, e_decode(0));
    add(1, 1, 0, e_memadr());
    add(1, 1, 0, e_memrd());
    add(1, 1, 0, e_memwb());
    add(1, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; memready = s.mr; zero = s.z;
      #1;
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL lw cyc%0d: got=%h want=%h", n, outs, e);
      end
      n++;
    end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [2:0] ac);
    step_t s;
    logic [15:0] e;
    int n = 0;
    op = 6'b000000; funct = fn;
    add(1, 1, 0, e_fetch(1));
    add(1, 1, 0, e_decode(0));
    add(1, 1, 0, e_exec(ac, 0));
    add(1, 1, 0, e_aluwb());
    add(1, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; memready = s.mr; zero = s.z;
      #1;
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL rtype_%b cyc%0d: got=%h want=%h", fn, n, outs, e);
      end
      n++;
    end
  endtask

  task automatic test_beq(input logic z);
    step_t s;
    logic [15:0] e;
    int n = 0;
    op = 6'b000100; funct = 6'b000000;
    add(1, 1, 0, e_fetch(1));
    add(1, 1, 0, e_decode(0));
    add(1, 1, z, e_branch(z));
    add(1, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; memready = s.mr; zero = s.z;
      #1;
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL beq_z%0d cyc%0d: got=%h want=%h", z, n, outs, e);
      end
      n++;
    end
  endtask

  task automatic test_addi_jump();
    step_t s;
    logic [15:0] e;
    int n = 0;
    op = 6'b001000; funct = 6'b111111;
    add(1, 1, 0, e_fetch(1));
    add(1, 1, 0, e_decode(0));
    add(1, 1, 0, e_memadr());
    add(1, 1, 0, e_addiwb());
    add(1, 1, 0, e_fetch(1));
    add(1, 1, 0, e_decode(0));
    add(1, 1, 0, e_jump());
    add(1, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; memready = s.mr; zero = s.z;
      if (n == 4) op = 6'b000010;
      #1;
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL addi_j cyc%0d: got=%h want=%h", n, outs, e);
      end
      n++;
    end
  endtask

  task automatic test_sw_stall();
    step_t s;
    logic [15:0] e;
    int n = 0;
    int mw0;
    op = 6'b101011; funct = 6'b000000;
    mw0 = mw_count;
    add(1, 1, 0, e_fetch(1));
    add(1, 1, 0, e_decode(0));
    add(1, 1, 0, e_memadr());
    add(1, 0, 0, e_memwr(0));
    add(1, 0, 0, e_memwr(0));
    add(1, 0, 0, e_memwr(0));
    add(1, 1, 0, e_memwr(1));
    add(1, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; memready = s.mr; zero = s.z;
      #1;
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL sw_stall cyc%0d: got=%h want=%h", n, outs, e);
      end
      n++;
    end
    total++;
    if (mw_count - mw0 !== 1) begin
      bad++;
      $display("FAIL sw_stall_pulses: got=%0d want=1", mw_count - mw0);
    end
  endtask

  task automatic test_illegal();
    step_t s;
    logic [15:0] e;
    int n = 0;
    int mw0;
    op = 6'b111111; funct = 6'b100000;
    mw0 = mw_count;
    add(1, 1, 0, e_fetch(1));
    add(1, 1, 0, e_decode(1));
    add(1, 1, 0, e_fetch(1));
    add(1, 1, 0, e_decode(0));
    add(1, 1, 0, e_exec(3'b000, 1));
    add(1, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; memready = s.mr; zero = s.z;
      if (n == 2) begin
        op = 6'b000000; funct = 6'b111000;
      end
      #1;
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL illegal cyc%0d: got=%h want=%h", n, outs, e);
      end
      n++;
    end
    total++;
    if (mw_count !== mw0) begin
      bad++;
      $display("FAIL illegal_nowrite: got=%0d want=%0d", mw_count, mw0);
    end
  endtask

  task automatic test_reset_mid_sw();
    step_t s;
    logic [15:0] e;
    int n = 0;
    int mw0;
    op = 6'b101011; funct = 6'b000000;
    mw0 = mw_count;
    add(1, 1, 0, e_fetch(1));
    add(1, 1, 0, e_decode(0));
    add(1, 1, 0, e_memadr());
    add(1, 0, 0, e_memwr(0));
    add(0, 1, 0, 16'h0);
    add(0, 1, 1, 16'h0);
    add(1, 0, 0, e_fetch(0));
    add(1, 1, 0, e_fetch(1));
    add(1, 1, 0, e_decode(0));
    add(1, 1, 0, e_memadr());
    add(1, 0, 0, e_memwr(0));
    add(0, 1, 0, 16'h0);
    add(1, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; memready = s.mr; zero = s.z;
      #1;
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL reset_mid_sw cyc%0d: got=%h want=%h", n, outs, e);
      end
      n++;
    end
    total++;
    if (mw_count !== mw0) begin
      bad++;
      $display("FAIL reset_mid_sw_nowrite: got=%0d want=%0d", mw_count, mw0);
    end
  endtask

  task automatic test_fetch_stall();
    step_t s;
    logic [15:0] e;
    int n = 0;
    op = 6'b100011; funct = 6'b000000;
    add(1, 0, 0, e_fetch(0));
    add(1, 0, 0, e_fetch(0));
    add(1, 1, 0, e_fetch(1));
    add(1, 1, 0, e_decode(0));
    add(1, 1, 0, e_memadr());
    add(1, 0, 0, e_memrd());
    add(1, 0, 0, e_memrd());
    add(1, 1, 0, e_memrd());
    add(1, 1, 0, e_memwb());
    add(1, 0, 0, e_fetch(0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = s.rst; memready = s.mr; zero = s.z;
      #1;
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL stall_lw cyc%0d: got=%h want=%h", n, outs, e);
      end
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; memready = 1'b0; zero = 1'b0; op = 6'b000000; funct = 6'b000000;
    #2 reset = 1'b0;
    test_reset();
    test_lw();
    test_rtype(6'b100010, 3'b110);
    test_rtype(6'b101010, 3'b111);
    test_rtype(6'b100101, 3'b001);
    test_beq(1'b1);
    test_beq(1'b0);
    test_addi_jump();
    test_sw_stall();
    test_illegal();
    test_reset_mid_sw();
    test_fetch_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
